aes_iter_enc: RTL and testbench
===============================

AES_ITER_ENC -- requirements
Module: aes_iter_enc

Interface
REQ-001 SHALL have parameter ROUNDS_PER_CYCLE, default 1, meaning the number of AES rounds evaluated per clock; legal values are 1, 2, 5 and 10.
REQ-002 SHALL have parameter KEY_BITS, default 128, meaning the cipher key length; only 128 is legal.
REQ-003 SHALL have port clk  input  1  clock, with all state updated on the rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port in_valid  input  1  the plaintext and key are presented.
REQ-006 SHALL have port in_ready  output  1  the core can accept a block.
REQ-007 SHALL have port key  input  128  the AES-128 cipher key (FIPS-197 byte order, byte 0 = [127:120]).
REQ-008 SHALL have port plaintext  input  128  the input block, in the same byte order.
REQ-009 SHALL have port out_valid  output  1  ciphertext is valid.
REQ-010 SHALL have port out_ready  input  1  the consumer accepts the ciphertext.
REQ-011 SHALL have port ciphertext  output  128  the encrypted block.
REQ-012 SHALL have port busy  output  1  high in RUN or DONE.

Function
REQ-013 SHALL implement a three-state FSM: IDLE, RUN and DONE.
REQ-014 SHALL assert in_ready only in IDLE; an accept occurs on a rising edge with in_valid && in_ready.
REQ-015 SHALL on accept register state = plaintext ^ key and round_key = key, set round counter = 1 and enter RUN.
REQ-016 SHALL in RUN apply ROUNDS_PER_CYCLE rounds per cycle, with on-the-fly key expansion (RotWord, SubWord, Rcon 01..36) and each round key derived in the same cycle it is used.
REQ-017 SHALL apply SubBytes, ShiftRows, MixColumns and AddRoundKey in rounds 1-9, and omit MixColumns in round 10.
REQ-018 SHALL enter DONE after round 10 completes and assert out_valid exactly 10/ROUNDS_PER_CYCLE cycles after the accept edge.
REQ-019 SHALL in DONE hold ciphertext and out_valid stable until out_ready is high, then return to IDLE on that edge.
REQ-020 SHALL keep in_ready low on the DONE->IDLE edge; back-to-back throughput is one block per 10/ROUNDS_PER_CYCLE + 2 cycles.
REQ-021 SHALL ignore key and plaintext changes while busy.
REQ-022 SHALL drive ciphertext to 0 outside DONE.
REQ-023 SHALL cause any elaboration with an illegal ROUNDS_PER_CYCLE to fail.

Reset
REQ-024 SHALL on rst_n low immediately force IDLE, with in_ready=1 (visible once rst_n is high), out_valid=0, busy=0, ciphertext=0, and the internal state, round key and counter at 0.
REQ-025 SHALL discard any block in flight when reset is asserted mid-RUN or mid-DONE, with no output produced.

Configuration
REQ-026 SHALL, when AES_BLK_CNT_EN is defined, add output port blk_cnt (32 bits, reset 0), incremented on each out_valid && out_ready edge and wrapping from FFFFFFFF to 0.
REQ-027 SHALL, when AES_BLK_CNT_EN is not defined, omit the blk_cnt port and its counter, with all other behaviour identical.

Verification
REQ-028 SHALL cover: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff, R=1 -> ct 69c4e0d86a7b0430d8cdb78070b4c55a, out_valid 10 cycles after accept.
REQ-029 SHALL cover: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734, for each R in {1,2,5,10} -> ct 3925841d02dc09fbdc118597196a0b32, latency 10, 5, 2 and 1 respectively.
REQ-030 SHALL cover: out_ready held low for 20 cycles in DONE -> ciphertext and out_valid stable, in_ready=0, and a second in_valid is not accepted.
REQ-031 SHALL cover: input bus changed every cycle during RUN -> ct equals that of the captured block.
REQ-032 SHALL cover: rst_n pulsed low at cycle 4 of RUN -> out_valid never rises, in_ready=1 after release, and the next block encrypts correctly.
REQ-033 SHALL cover: with AES_BLK_CNT_EN defined, blk_cnt forced to FFFFFFFF and one block completed -> blk_cnt=00000000.

Source files
------------

// File: rtl/aes_iter_enc.sv
// Iterative AES-128 encryptor: ROUNDS_PER_CYCLE rounds per clock with on-the-fly key expansion.
// Optional block counter output enabled by defining AES_BLK_CNT_EN.
module aes_iter_enc #(
  parameter int ROUNDS_PER_CYCLE = 1,
  parameter int KEY_BITS         = 128
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] key,
  input  logic [127:0] plaintext,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] ciphertext,
  output logic         busy
`ifdef AES_BLK_CNT_EN
  ,
  output logic [31:0]  blk_cnt
`endif
);

  if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 ||
        ROUNDS_PER_CYCLE == 5 || ROUNDS_PER_CYCLE == 10)) begin : g_badRounds
    $error("aes_iter_enc: ROUNDS_PER_CYCLE must be 1, 2, 5 or 10");
  end
  if (KEY_BITS != 128) begin : g_badKeyBits
    $error("aes_iter_enc: only KEY_BITS = 128 is supported");
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[{~x, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] rnd);
    case (rnd)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [31:0] subWord(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // Derives the next round key from the previous one (RotWord, SubWord, Rcon).
  function automatic logic [127:0] expandKey(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] t, n0, n1, n2, n3;
    t  = subWord({k[23:0], k[31:24]}) ^ {rc, 24'h000000};
    n0 = k[127:96] ^ t;
    n1 = k[95:64] ^ n0;
    n2 = k[63:32] ^ n1;
    n3 = k[31:0] ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  function automatic logic [31:0] mixColumn(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  // Byte i of the state sits at [127-8i]; byte (row r, column c) is index 4c+r.
  function automatic logic [127:0] aesRound(input logic [127:0] s, input logic [127:0] rk,
                                            input logic last);
    logic [127:0] shifted, mixed;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        shifted[127-8*(4*c+r) -: 8] = sbox(s[127-8*(4*((c+r)%4)+r) -: 8]);
      end
    end
    for (int c = 0; c < 4; c++) begin
      mixed[127-32*c -: 32] = mixColumn(shifted[127-32*c -: 32]);
    end
    return (last ? shifted : mixed) ^ rk;
  endfunction

  state_t        r_fsm, w_fsmNext;
  logic [127:0]  r_state, r_key;
  logic [3:0]    r_round;
  logic [127:0]  w_nextState, w_nextKey;
  logic          w_accept, w_lastStep;

  assign w_accept   = (r_fsm == S_IDLE) && in_valid;
  assign w_lastStep = (r_round + 4'(ROUNDS_PER_CYCLE - 1)) == 4'd10;

  always_comb begin
    w_nextState = r_state;
    w_nextKey   = r_key;
    for (int i = 0; i < ROUNDS_PER_CYCLE; i++) begin
      w_nextKey   = expandKey(w_nextKey, rcon(r_round + 4'(i)));
      w_nextState = aesRound(w_nextState, w_nextKey, (r_round + 4'(i)) == 4'd10);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fsm <= S_IDLE;
    end else begin
      r_fsm <= w_fsmNext;
    end
  end

  always_comb begin
    w_fsmNext  = r_fsm;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b1;
    ciphertext = '0;
    case (r_fsm)
      S_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) w_fsmNext = S_RUN;
      end
      S_RUN: begin
        if (w_lastStep) w_fsmNext = S_DONE;
      end
      S_DONE: begin
        out_valid  = 1'b1;
        ciphertext = r_state;
        if (out_ready) w_fsmNext = S_IDLE;
      end
      default: w_fsmNext = S_IDLE;
    endcase
  end

  // Datapath only moves on accept or while running; DONE holds the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= '0;
      r_key   <= '0;
      r_round <= '0;
    end else if (w_accept) begin
      r_state <= plaintext ^ key;
      r_key   <= key;
      r_round <= 4'd1;
    end else if (r_fsm == S_RUN) begin
      r_state <= w_nextState;
      r_key   <= w_nextKey;
      r_round <= r_round + 4'(ROUNDS_PER_CYCLE);
    end
  end

`ifdef AES_BLK_CNT_EN
  logic [31:0] r_blkCnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_blkCnt <= '0;
    end else if (out_valid && out_ready) begin
      r_blkCnt <= r_blkCnt + 32'd1;
    end
  end

  assign blk_cnt = r_blkCnt;
`endif

endmodule

// File: tb/tb_aes_iter_enc.sv
// Directed bench for aes_iter_enc: one instance per legal ROUNDS_PER_CYCLE, known-answer vectors
// plus hand-written hold, bus-scramble and mid-run reset sequences.
module tb_aes_iter_enc;

  localparam logic [127:0] K_A  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P_A  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C_A  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] P_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] C_Z  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  typedef struct {
    int           idx;
    logic [127:0] key;
    logic [127:0] pt;
    logic [127:0] ct;
    int           lat;
  } vec_t;

  logic         clk;
  logic         rst_n;
  logic [127:0] key, pt;
  logic         iv[4];
  logic         ordy[4];
  logic         ir[4];
  logic         ov[4];
  logic         bz[4];
  logic [127:0] ct[4];
`ifdef AES_BLK_CNT_EN
  logic [31:0]  bc[4];
`endif

  int checks;
  int errors;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    aes_iter_enc #(
      .ROUNDS_PER_CYCLE((g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 5 : 10),
      .KEY_BITS(128)
    ) u_dut (
      .clk(clk),
      .rst_n(rst_n),
      .in_valid(iv[g]),
      .in_ready(ir[g]),
      .key(key),
      .plaintext(pt),
      .out_valid(ov[g]),
      .out_ready(ordy[g]),
      .ciphertext(ct[g]),
      .busy(bz[g])
`ifdef AES_BLK_CNT_EN
      ,
      .blk_cnt(bc[g])
`endif
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog expired actual=running required=finished");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Waits for in_ready, presents one block, and counts cycles from the accept edge to out_valid.
  task automatic applyStimulus(input int idx, input logic [127:0] k, input logic [127:0] p,
                               output int lat);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!ir[idx] && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("inReadyWait", 128'(ir[idx]), 128'd1);
    key = k;
    pt = p;
    iv[idx] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv[idx] = 1'b0;
    lat = 0;
    while (!ov[idx] && lat < 50) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic drainBlock(input int idx, input string name);
    checkOutput({name, "ReadyLowInDone"}, 128'(ir[idx]), 128'd0);
    ordy[idx] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ordy[idx] = 1'b0;
    checkOutput({name, "DrainValid"}, 128'(ov[idx]), 128'd0);
    checkOutput({name, "DrainCt"}, ct[idx], 128'd0);
    checkOutput({name, "DrainReady"}, 128'(ir[idx]), 128'd1);
  endtask

  initial begin
    vec_t vecs[7];
    int   lat;
    logic sawValid;

    vecs[0] = '{0, K_A, P_A, C_A, 10};
    vecs[1] = '{0, K_B, P_B, C_B, 10};
    vecs[2] = '{1, K_B, P_B, C_B, 5};
    vecs[3] = '{2, K_B, P_B, C_B, 2};
    vecs[4] = '{3, K_B, P_B, C_B, 1};
    vecs[5] = '{1, 128'd0, 128'd0, C_Z, 5};
    vecs[6] = '{3, 128'd0, 128'd0, C_Z, 1};

    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    key = '0;
    pt = '0;
    for (int i = 0; i < 4; i++) begin
      iv[i] = 1'b0;
      ordy[i] = 1'b0;
    end

    repeat (2) @(negedge clk);
    checkOutput("rstValid", 128'(ov[0]), 128'd0);
    checkOutput("rstBusy", 128'(bz[0]), 128'd0);
    checkOutput("rstCt", ct[0], 128'd0);
`ifdef AES_BLK_CNT_EN
    checkOutput("rstBlkCnt", 128'(bc[0]), 128'd0);
`endif
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("rstReady%0d", i), 128'(ir[i]), 128'd1);
    end

    for (int v = 0; v < 7; v++) begin
      applyStimulus(vecs[v].idx, vecs[v].key, vecs[v].pt, lat);
      checkOutput($sformatf("vec%0dLatency", v), 128'(lat), 128'(vecs[v].lat));
      checkOutput($sformatf("vec%0dCt", v), ct[vecs[v].idx], vecs[v].ct);
      checkOutput($sformatf("vec%0dBusy", v), 128'(bz[vecs[v].idx]), 128'd1);
      drainBlock(vecs[v].idx, $sformatf("vec%0d", v));
    end

    // Consumer stalls for 20 cycles while a second block is offered.
    applyStimulus(0, K_B, P_B, lat);
    checkOutput("holdLatency", 128'(lat), 128'd10);
    key = K_A;
    pt = P_A;
    iv[0] = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput($sformatf("holdCt%0d", c), ct[0], C_B);
      checkOutput($sformatf("holdValid%0d", c), 128'(ov[0]), 128'd1);
      checkOutput($sformatf("holdReady%0d", c), 128'(ir[0]), 128'd0);
    end
    iv[0] = 1'b0;
    drainBlock(0, "hold");
    @(negedge clk);
    checkOutput("holdNoSecondBlock", 128'(bz[0]), 128'd0);

    // Input bus scrambled every cycle during RUN.
    key = K_B;
    pt = P_B;
    iv[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    lat = 0;
    while (!ov[0] && lat < 50) begin
      key = {$urandom(), $urandom(), $urandom(), $urandom()};
      pt = {$urandom(), $urandom(), $urandom(), $urandom()};
      iv[0] = 1'($urandom_range(0, 1));
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    iv[0] = 1'b0;
    checkOutput("scrambleLatency", 128'(lat), 128'd10);
    checkOutput("scrambleCt", ct[0], C_B);
    drainBlock(0, "scramble");

    // Reset pulsed during the fourth RUN cycle discards the block.
    key = K_B;
    pt = P_B;
    iv[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv[0] = 1'b0;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    checkOutput("midRstValid", 128'(ov[0]), 128'd0);
    checkOutput("midRstBusy", 128'(bz[0]), 128'd0);
    checkOutput("midRstCt", ct[0], 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("postRstReady", 128'(ir[0]), 128'd1);
    sawValid = 1'b0;
    repeat (15) begin
      @(posedge clk);
      @(negedge clk);
      if (ov[0]) sawValid = 1'b1;
    end
    checkOutput("postRstNoValid", 128'(sawValid), 128'd0);
    applyStimulus(0, K_A, P_A, lat);
    checkOutput("postRstLatency", 128'(lat), 128'd10);
    checkOutput("postRstCt", ct[0], C_A);
    drainBlock(0, "postRst");

`ifdef AES_BLK_CNT_EN
    checkOutput("blkCntOne", 128'(bc[0]), 128'd1);
    force g_dut[0].u_dut.r_blkCnt = 32'hffffffff;
    @(negedge clk);
    release g_dut[0].u_dut.r_blkCnt;
    checkOutput("blkCntForced", 128'(bc[0]), 128'hffffffff);
    applyStimulus(0, K_B, P_B, lat);
    checkOutput("blkCntWrapCt", ct[0], C_B);
    drainBlock(0, "blkCntWrap");
    checkOutput("blkCntWrap", 128'(bc[0]), 128'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
